// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: downstream control, instruction-memory port and IF/ID outputs.
// master = the fetch stage, slave = decode/memory side.
interface fetch_stage_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_data_i;
    logic              ifid_valid_o;
    logic [DATA_W-1:0] ifid_instr_o;
    logic [ADDR_W-1:0] ifid_pc_o;
    logic [ADDR_W-1:0] ifid_pc_next_o;
    logic              halted_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc_next_o, halted_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc_next_o, halted_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: PC ownership, stall, redirect and halt-on-HALT_WORD.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_stage #(
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 SysCLK,
    input  logic                 RST,
    fetch_stage_if.master        bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} fetchState_t;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    fetchState_t       stateReg, stateNext;
    logic [ADDR_W-1:0] pcReg, pcNext, pcInc;
    logic              validReg, validNext;
    logic [DATA_W-1:0] instrReg, instrNext;
    logic [ADDR_W-1:0] ifPcReg, ifPcNext;
    logic [ADDR_W-1:0] ifPcIncReg, ifPcIncNext;
    logic              haltedReg, haltedNext;
    logic              writeFetch, countStall;

    assign pcInc = pcReg + PC_ONE;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateNext   = stateReg;
        pcNext      = pcReg;
        validNext   = validReg;
        instrNext   = instrReg;
        ifPcNext    = ifPcReg;
        ifPcIncNext = ifPcIncReg;
        haltedNext  = haltedReg;
        writeFetch  = 1'b0;
        countStall  = 1'b0;

        case (stateReg)
            BOOT: begin
                validNext = 1'b0;
                instrNext = '0;
                stateNext = RUN;
                if (bus.redirect_i) pcNext = bus.redirect_pc_i;
            end
            RUN: begin
                if (bus.redirect_i) begin
                    pcNext    = bus.redirect_pc_i;
                    validNext = 1'b0;
                    instrNext = '0;
                end else if (bus.stall_i) begin
                    countStall = 1'b1;
                end else begin
                    validNext   = 1'b1;
                    instrNext   = bus.imem_data_i;
                    ifPcNext    = pcReg;
                    ifPcIncNext = pcInc;
                    writeFetch  = 1'b1;
                    // The halt word still goes to decode; only the PC freezes.
                    if (bus.imem_data_i == HALT_WORD) begin
                        stateNext  = HALTED;
                        haltedNext = 1'b1;
                    end else begin
                        pcNext = pcInc;
                    end
                end
            end
            HALTED: begin
                if (bus.redirect_i) begin
                    pcNext     = bus.redirect_pc_i;
                    validNext  = 1'b0;
                    instrNext  = '0;
                    haltedNext = 1'b0;
                    stateNext  = RUN;
                end else if (!bus.stall_i) begin
                    validNext = 1'b0;
                    instrNext = '0;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge SysCLK or negedge RST) begin
        if (!RST) begin
            stateReg   <= BOOT;
            pcReg      <= RESET_PC;
            validReg   <= 1'b0;
            instrReg   <= '0;
            ifPcReg    <= '0;
            ifPcIncReg <= '0;
            haltedReg  <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            pcReg      <= pcNext;
            validReg   <= validNext;
            instrReg   <= instrNext;
            ifPcReg    <= ifPcNext;
            ifPcIncReg <= ifPcIncNext;
            haltedReg  <= haltedNext;
        end
    end

    assign bus.imem_addr_o    = pcReg;
    assign bus.ifid_valid_o   = validReg;
    assign bus.ifid_instr_o   = instrReg;
    assign bus.ifid_pc_o      = ifPcReg;
    assign bus.ifid_pc_next_o = ifPcIncReg;
    assign bus.halted_o       = haltedReg;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCnt, stallCnt;

    always_ff @(posedge SysCLK or negedge RST) begin
        if (!RST) begin
            fetchCnt <= '0;
            stallCnt <= '0;
        end else begin
            if (writeFetch && fetchCnt != 32'hFFFF_FFFF) fetchCnt <= fetchCnt + 32'd1;
            if (countStall && stallCnt != 32'hFFFF_FFFF) stallCnt <= stallCnt + 32'd1;
        end
    end

    assign fetch_cnt_o = fetchCnt;
    assign stall_cnt_o = stallCnt;
`else
    logic unusedPerf;
    assign unusedPerf = writeFetch ^ countStall;
`endif
endmodule
